eqed_detect_monitor: RTL

Observation-side companion to the EQED bit-flip injector: watches a golden copy and a fault-injected copy of a design's outputs, compacts both into MISR signatures, and classifies each injection as detected (with latency) or masked (timeout). It sits in the EQED harness beside the one-hot injection decoder. It consumes that decoder's "injection happened" pulse and selected-FF index, and reports a per-run verdict to the formal or sim bench.

---
 rtl/eqed_detect_monitor.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/eqed_detect_monitor.sv
// eqed_detect_monitor: compares a golden and a fault-injected copy of a design's
// outputs after a single bit-flip injection, compacts both into MISR signatures,
// and classifies the run as detected (with latency), masked (timeout) or spurious.
//
// Ports:
//   clk, rst        clock (posedge) and synchronous active-high reset
//   start           arm a new run (restarts any run in progress)
//   inj_valid       injection pulse from the one-hot injection decoder
//   inj_idx         index of the flipped FF, valid with inj_valid
//   gold_out        outputs of the fault-free copy
//   dut_out         outputs of the injected copy
//   busy, done      run in progress / verdict available
//   detected        run ended on a mismatch after injection
//   masked          run ended on timeout without mismatch
//   spurious        mismatch seen before or with the injection
//   latency         cycles from injection to first mismatch (TIMEOUT if masked)
//   fault_idx       captured inj_idx
//   gold_sig        golden MISR signature
//   dut_sig         injected-copy MISR signature
//   sig_mismatch    gold_sig != dut_sig (combinational)
module eqed_detect_monitor #(
  parameter int unsigned OUT_W   = 3,
  parameter int unsigned SIG_W   = 6,
  parameter int unsigned IDX_W   = 4,
  parameter int unsigned CNT_W   = 10,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             inj_valid,
  input  logic [IDX_W-1:0] inj_idx,
  input  logic [OUT_W-1:0] gold_out,
  input  logic [OUT_W-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             detected,
  output logic             masked,
  output logic             spurious,
  output logic [CNT_W-1:0] latency,
  output logic [IDX_W-1:0] fault_idx,
  output logic [SIG_W-1:0] gold_sig,
  output logic [SIG_W-1:0] dut_sig,
  output logic             sig_mismatch
);

  localparam logic [SIG_W-1:0] SEED      = SIG_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    TRACK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             mismatch;

  logic seed_load, misr_en, cap_idx, cnt_init, cnt_inc;
  logic set_det, set_mask, set_spur;

  // One MISR step: even bits 2k take input bit k, bit 0 also takes the feedback.
  function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0] s,
                                                 input logic [OUT_W-1:0] din);
    logic [SIG_W-1:0] n;
    n    = '0;
    n[0] = s[SIG_W-1] ^ s[SIG_W-2] ^ din[0];
    for (int j = 1; j < int'(SIG_W); j++) begin
      if ((j % 2 == 0) && (j / 2 < int'(OUT_W)))
        n[j] = s[j-1] ^ din[j/2];
      else
        n[j] = s[j-1];
    end
    return n;
  endfunction

  assign mismatch     = (gold_out != dut_out);
  assign sig_mismatch = (gold_sig != dut_sig);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and datapath control; start overrides everything else
  always_comb begin
    state_d   = state_q;
    seed_load = 1'b0;
    misr_en   = 1'b0;
    cap_idx   = 1'b0;
    cnt_init  = 1'b0;
    cnt_inc   = 1'b0;
    set_det   = 1'b0;
    set_mask  = 1'b0;
    set_spur  = 1'b0;
    if (start) begin
      state_d   = ARMED;
      seed_load = 1'b1;
    end else begin
      unique case (state_q)
        ARMED: begin
          misr_en = 1'b1;
          if (mismatch) begin
            state_d  = DONE;
            set_spur = 1'b1;
          end else if (inj_valid) begin
            state_d  = TRACK;
            cap_idx  = 1'b1;
            cnt_init = 1'b1;
          end
        end
        TRACK: begin
          misr_en = 1'b1;
          if (mismatch) begin
            state_d = DONE;
            set_det = 1'b1;
          end else if (cnt_q == TIMEOUT_C) begin
            state_d  = DONE;
            set_mask = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Registered outputs, signatures and the injection-relative cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      detected  <= 1'b0;
      masked    <= 1'b0;
      spurious  <= 1'b0;
      latency   <= '0;
      fault_idx <= '0;
      gold_sig  <= SEED;
      dut_sig   <= SEED;
      cnt_q     <= '0;
    end else begin
      busy <= (state_d == ARMED) || (state_d == TRACK);
      done <= (state_d == DONE);
      if (seed_load) begin
        detected  <= 1'b0;
        masked    <= 1'b0;
        spurious  <= 1'b0;
        latency   <= '0;
        fault_idx <= '0;
        gold_sig  <= SEED;
        dut_sig   <= SEED;
        cnt_q     <= '0;
      end else begin
        if (misr_en) begin
          gold_sig <= misr_next(gold_sig, gold_out);
          dut_sig  <= misr_next(dut_sig, dut_out);
        end
        if (cap_idx) fault_idx <= inj_idx;
        // cnt holds the TRACK-cycle number, so it is 1 in the first TRACK cycle
        if (cnt_init) cnt_q <= CNT_W'(1);
        if (cnt_inc)  cnt_q <= cnt_q + CNT_W'(1);
        if (set_det) begin
          detected <= 1'b1;
          latency  <= cnt_q;
        end
        if (set_mask) begin
          masked  <= 1'b1;
          latency <= TIMEOUT_C;
        end
        if (set_spur) spurious <= 1'b1;
      end
    end
  end

endmodule
